seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Iterative 64x64 shift-and-add multiplier. It sits directly downstream of the 64-bit ripple adder datapath.
- Each iteration conditionally adds the multiplicand into the upper half of a 128-bit accumulator, then shifts.
- It serves MUL/MULH-class instructions: the execute stage stalls on busy and consumes the 128-bit product when done pulses.

Parameters:
- WIDTH, 64, operand width; product is 2*WIDTH bits.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock; only clock in the block.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result valid.
- product_hi  output  WIDTH  upper half of the 2*WIDTH product.
- product_lo  output  WIDTH  lower half of the 2*WIDTH product.
- ovrflow  output  1  product does not fit in WIDTH bits for the selected signedness.

Behaviour:
- Reset is synchronous, evaluated on clk rise, and has priority over everything. After reset:
  - state = IDLE
  - busy = 0, done = 0, ovrflow = 0
  - product_hi = 0, product_lo = 0
  - internal registers are cleared.
- States: IDLE, RUN, SIGN, DONE.
- IDLE:
  - On the edge with start=1 (edge E0), latch the operands:
    - mcand = |a| if signed_op else a
    - mplier = |b| if signed_op else b
    - neg = signed_op & (a[63] ^ b[63])
    - acc = {64'b0, mplier}, cnt = 0
  - Go to RUN. busy rises after E0.
  - |x| of -2^63 is 2^63, which is representable as unsigned 64-bit.
- RUN, one iteration per edge:
  - If acc[0]=1: {c, s} = acc[127:64] + mcand using a 64-bit add with carry-out. Otherwise {c, s} = {0, acc[127:64]}.
  - acc <= {c, s, acc[63:1]}.
  - cnt <= cnt + 1.
  - After the 64th RUN edge (E64), go to SIGN.
- SIGN, one edge (E65):
  - If neg, acc <= ~acc + 1 (128-bit two's-complement negate); else acc is unchanged.
  - Go to DONE.
- DONE, one cycle:
  - done = 1, busy = 0.
  - product_hi/product_lo show acc.
  - ovrflow is valid:
    - unsigned: product_hi != 0
    - signed: product_hi != {64{product_lo[63]}}
  - Next edge goes to IDLE. A start seen in DONE is ignored; it is sampled again in IDLE.
- Latency:
  - done is high in exactly the cycle after edge E65 (65 edges after start is accepted).
  - The next start is accepted no earlier than E66 + 1 cycle idle.
- busy is 1 in RUN and SIGN, and 0 in IDLE and DONE.
- Result hold: product_hi/product_lo/ovrflow hold their values after DONE until the next accepted start or reset.
- Inputs a/b/signed_op may change freely while busy; only the values latched at E0 are used.
- start while busy (RUN/SIGN) is ignored. It is not queued and does not restart the operation.
- Reset mid-operation (any state) aborts:
  - returns to IDLE
  - zeroes all outputs
  - the partial product is discarded
  - no done pulse is produced.
- Carry-out of the per-iteration add is shifted into acc[127] and never lost. The adder's own overflow flag is unused.
- Latency is fixed; there is no early termination for zero operands.

Test Plan:
- Unsigned small: reset, then start with signed_op=0, a=3, b=5 -> done exactly 65 edges after the start edge; product_hi=0, product_lo=15, ovrflow=0; busy low in the done cycle.
- Signed mixed: signed_op=1, a=-3 (0xFFFF_FFFF_FFFF_FFFD), b=5 -> product_hi=0xFFFF_FFFF_FFFF_FFFF, product_lo=0xFFFF_FFFF_FFFF_FFF1, ovrflow=0.
- Unsigned max: signed_op=0, a=b=0xFFFF_FFFF_FFFF_FFFF -> product_hi=0xFFFF_FFFF_FFFF_FFFE, product_lo=0x1, ovrflow=1.
- Signed corner: signed_op=1, a=0x8000_0000_0000_0000, b=-1 -> product_hi=0, product_lo=0x8000_0000_0000_0000, ovrflow=1.
- Handshake: while busy, assert start with a=7, b=7, and change a/b -> first result is unaffected; exactly one done pulse; after return to IDLE, a new start with 7x7 gives product_lo=49.
- Reset mid-op: start 3x5, assert reset at cycle 30 -> next cycle busy=0, done=0, products=0; no done pulse follows; a subsequent 2x2 gives product_lo=4.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier: one accumulator step per clock, sign fix-up
// applied once at the end, so latency is fixed at 65 edges from accepted start to done.
module seq_multiplier #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product_hi,
   output logic [WIDTH-1:0] product_lo,
   output logic             ovrflow
);

   typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

   localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_nextState;
   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_neg;
   logic               r_signed;
   logic               r_ovf;

   logic [WIDTH-1:0]   w_absA;
   logic [WIDTH-1:0]   w_absB;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_signAcc;
   logic               w_ovf;

   // The most negative operand negates to itself, which reads correctly as unsigned 2^(WIDTH-1)
   assign w_absA = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign w_absB = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

   assign w_sum = r_acc[0] ? ({1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                           : {1'b0, r_acc[2*WIDTH-1:WIDTH]};

   assign w_signAcc = r_neg ? (~r_acc + ONE_P) : r_acc;

   assign w_ovf = r_signed ? (w_signAcc[2*WIDTH-1:WIDTH] != {WIDTH{w_signAcc[WIDTH-1]}})
                           : (w_signAcc[2*WIDTH-1:WIDTH] != '0);

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = RUN;
         RUN:     if (r_cnt == LAST_ITER) w_nextState = SIGN;
         SIGN:    w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == RUN) || (r_state == SIGN);
      done = (r_state == DONE);
   end

   // The accumulator doubles as the result register; it is only rewritten by a new start
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mcand  <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_signed <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= w_absA;
                  r_acc    <= {{WIDTH{1'b0}}, w_absB};
                  r_cnt    <= '0;
                  r_neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_signed <= signed_op;
                  r_ovf    <= 1'b0;
               end
            end
            RUN: begin
               r_acc <= {w_sum, r_acc[WIDTH-1:1]};
               r_cnt <= r_cnt + CNT_W'(1);
            end
            SIGN: begin
               r_acc <= w_signAcc;
               r_ovf <= w_ovf;
            end
            default: ;
         endcase
      end
   end

   assign product_hi = r_acc[2*WIDTH-1:WIDTH];
   assign product_lo = r_acc[WIDTH-1:0];
   assign ovrflow    = r_ovf;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: hand-computed products, latency, handshake and
// mid-operation reset behaviour.
module tb_seq_multiplier;

   logic        clk;
   logic        reset;
   logic        start;
   logic        signed_op;
   logic [63:0] a;
   logic [63:0] b;
   logic        busy;
   logic        done;
   logic [63:0] product_hi;
   logic [63:0] product_lo;
   logic        ovrflow;

   int testsRun;
   int testsFailed;
   int latency;
   int doneCount;

   seq_multiplier #(.WIDTH(64), .CNT_W(7)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .signed_op  (signed_op),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .product_hi (product_hi),
      .product_lo (product_lo),
      .ovrflow    (ovrflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one request, lets it be accepted on the next edge, then measures edges to done
   task automatic applyStimulus(input logic sgn, input logic [63:0] opA, input logic [63:0] opB,
                                output int lat);
      @(negedge clk);
      start     = 1'b1;
      signed_op = sgn;
      a         = opA;
      b         = opB;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done) break;
      end
   endtask

   task automatic checkResult(input string tag, input logic [63:0] expHi,
                              input logic [63:0] expLo, input logic expOvf);
      checkOutput({tag, "_hi"}, {64'd0, product_hi}, {64'd0, expHi});
      checkOutput({tag, "_lo"}, {64'd0, product_lo}, {64'd0, expLo});
      checkOutput({tag, "_ovf"}, {127'd0, ovrflow}, {127'd0, expOvf});
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b1;
      start       = 1'b0;
      signed_op   = 1'b0;
      a           = '0;
      b           = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy", {127'd0, busy}, 128'd0);
      checkOutput("reset_done", {127'd0, done}, 128'd0);
      checkResult("reset", 64'd0, 64'd0, 1'b0);
      reset = 1'b0;

      // Unsigned small
      applyStimulus(1'b0, 64'd3, 64'd5, latency);
      checkOutput("u3x5_latency", 128'(latency), 128'd65);
      checkOutput("u3x5_busy_in_done", {127'd0, busy}, 128'd0);
      checkResult("u3x5", 64'd0, 64'd15, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("u3x5_done_cleared", {127'd0, done}, 128'd0);
      checkResult("u3x5_hold", 64'd0, 64'd15, 1'b0);

      // Signed mixed: -3 * 5 = -15
      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, latency);
      checkOutput("s_neg3x5_latency", 128'(latency), 128'd65);
      checkResult("s_neg3x5", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);

      // Unsigned max squared
      applyStimulus(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, latency);
      checkResult("u_max", 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 1'b1);

      // Most negative times -1 gives +2^63, which overflows signed 64-bit
      applyStimulus(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, latency);
      checkResult("s_min_x_neg1", 64'd0, 64'h8000_0000_0000_0000, 1'b1);

      // Signed negative times negative: -4 * -6 = 24
      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFA, latency);
      checkResult("s_neg4xneg6", 64'd0, 64'd24, 1'b0);

      // Start and operand churn while busy must not disturb the running 3x5
      @(negedge clk);
      start     = 1'b1;
      signed_op = 1'b0;
      a         = 64'd3;
      b         = 64'd5;
      @(posedge clk);
      #1;
      start     = 1'b0;
      latency   = 0;
      doneCount = 0;
      while (latency < 200) begin
         @(posedge clk);
         latency++;
         @(negedge clk);
         if (latency == 10) checkOutput("hs_busy_mid", {127'd0, busy}, 128'd1);
         if (done) begin
            doneCount++;
            break;
         end
         start     = (latency >= 3 && latency < 60);
         signed_op = latency[0];
         a         = (latency < 20) ? 64'd7 : 64'hDEAD_0000 + 64'(latency);
         b         = (latency < 20) ? 64'd7 : 64'hBEEF_0000 - 64'(latency);
      end
      start = 1'b0;
      checkOutput("hs_latency", 128'(latency), 128'd65);
      checkResult("hs_first", 64'd0, 64'd15, 1'b0);
      repeat (80) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("hs_done_pulses", 128'(doneCount), 128'd1);
      applyStimulus(1'b0, 64'd7, 64'd7, latency);
      checkResult("hs_7x7", 64'd0, 64'd49, 1'b0);

      // Reset in the middle of a run aborts it with no done pulse
      @(negedge clk);
      start     = 1'b1;
      signed_op = 1'b0;
      a         = 64'd3;
      b         = 64'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (30) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid_busy", {127'd0, busy}, 128'd0);
      checkOutput("rst_mid_done", {127'd0, done}, 128'd0);
      checkResult("rst_mid", 64'd0, 64'd0, 1'b0);
      reset     = 1'b0;
      doneCount = 0;
      repeat (80) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("rst_mid_no_done", 128'(doneCount), 128'd0);
      applyStimulus(1'b0, 64'd2, 64'd2, latency);
      checkOutput("post_rst_latency", 128'(latency), 128'd65);
      checkResult("post_rst_2x2", 64'd0, 64'd4, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
